// File: rtl/jstk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jstk_pkg
//  Description : Shared types and constants for the PmodJSTK SPI master:
//                controller state encoding and transaction geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package jstk_pkg;

    localparam int NUM_BYTES = 5;                   // bytes per transaction
    localparam int BYTE_W    = 8;                   // bits per byte
    localparam int DOUT_W    = NUM_BYTES * BYTE_W;  // received word width
    localparam int BCNT_W    = $clog2(NUM_BYTES);   // byte counter width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_mode0_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mode0_shifter
//  Description : One-byte SPI mode-0 shifter, MSB first. Loads a byte on
//                i_start, presents bit 7 on MOSI immediately, then produces
//                exactly 8 SCLK pulses paced by the divider enables. MISO is
//                sampled on each rising edge, MOSI advances on each falling
//                edge. o_done rises with the falling edge that ends pulse 8
//                and stays high until the next i_start.
//  Ports       : clk, rst          - system clock, sync active-high reset
//                i_rise_en/fall_en - one-cycle serial-clock edge enables
//                i_start           - load i_tx_byte and begin a byte
//                i_miso            - serial data in
//                o_sclk, o_mosi    - serial clock / data out (registered)
//                o_rx_byte         - byte received in the last transfer
//                o_done            - byte complete
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mode0_shifter
    import jstk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rise_en,
    input  logic              i_fall_en,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_tx_byte,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [BYTE_W-1:0] o_rx_byte,
    output logic              o_done
);

    localparam int c_CNT_W = $clog2(BYTE_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(BYTE_W);

    logic [BYTE_W-1:0]  r_tx_sr;    // MSB is the bit currently on MOSI
    logic [BYTE_W-1:0]  r_rx_sr;
    logic [c_CNT_W-1:0] r_bit_cnt;  // rising SCLK edges seen in this byte
    logic               r_active;
    logic               r_sclk;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b0;
            r_sclk    <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_start) begin
            // Start lands on a rising enable; SCLK is held low through it so
            // MOSI has a full half period of setup before the first rise.
            r_tx_sr   <= i_tx_byte;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b1;
            r_sclk    <= 1'b0;
            r_done    <= 1'b0;
        end else if (r_active) begin
            if (i_rise_en) begin
                r_sclk    <= 1'b1;
                r_rx_sr   <= {r_rx_sr[BYTE_W-2:0], i_miso};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (i_fall_en) begin
                r_sclk <= 1'b0;
                if (r_bit_cnt == c_LAST_BIT) begin
                    // End of pulse 8: release the line, MOSI returns to 0.
                    r_active <= 1'b0;
                    r_done   <= 1'b0 | 1'b1;
                    r_tx_sr  <= '0;
                end else if (r_bit_cnt != '0) begin
                    // The fall preceding the first rise must not shift.
                    r_tx_sr <= {r_tx_sr[BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_tx_sr[BYTE_W-1];
    assign o_rx_byte = r_rx_sr;
    assign o_done    = r_done;

endmodule
`default_nettype wire

// File: rtl/jstk_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : jstk_spi_master
//  Description : SPI mode-0 master for the PmodJSTK. Divides CLK by
//                2*HALF_DIV into a serial clock used purely as enables and
//                runs one 5-byte transaction per sndRec assertion: DIN, then
//                four 0x00 bytes. The 40 received bits appear on DOUT
//                (first byte in [39:32]) in the same cycle SS returns high.
//  Ports       : CLK, RST (sync, active high), sndRec (request level),
//                DIN (command byte), MISO / SS, SCLK, MOSI (Pmod pins),
//                DOUT (received data).
//  Options     : `define INTERBYTE_GAP_EN inserts one extra serial period
//                with SS low between consecutive bytes. DOUT is unaffected.
//  Revision    : 1.0 - initial release
// ============================================================================
module jstk_spi_master
    import jstk_pkg::*;
#(
    parameter int HALF_DIV = 750    // CLK cycles per half serial period, >= 2
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              sndRec,
    input  logic [BYTE_W-1:0] DIN,
    input  logic              MISO,
    output logic              SS,
    output logic              SCLK,
    output logic              MOSI,
    output logic [DOUT_W-1:0] DOUT
);

    localparam int                  c_DIV_W     = $clog2(HALF_DIV);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(HALF_DIV - 1);
    localparam logic [BCNT_W-1:0]   c_LAST_BYTE = BCNT_W'(NUM_BYTES - 1);
    localparam int                  c_ACC_W     = DOUT_W - BYTE_W;

    // ------------------------------------------------------------------
    // Serial-clock divider
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_isclk;
    logic               w_tc;
    logic               w_rise_en;
    logic               w_fall_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div_cnt <= '0;
            r_isclk   <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_isclk   <= ~r_isclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_tc      = (r_div_cnt == c_DIV_LAST);
    assign w_rise_en = w_tc & ~r_isclk;
    assign w_fall_en = w_tc &  r_isclk;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [BYTE_W-1:0]   r_tx_byte;
    logic [BCNT_W-1:0]   r_byte_cnt;
    // Only the first four bytes need storing; the fifth completes DOUT.
    logic [c_ACC_W-1:0]  r_acc;
    logic [DOUT_W-1:0]   r_dout;
    logic                r_ss;
`ifdef INTERBYTE_GAP_EN
    logic                r_gap;     // extra WAIT period still owed
`endif

    logic                w_get_byte;
    logic                w_done;
    logic [BYTE_W-1:0]   w_rx_byte;
    logic [DOUT_W-1:0]   w_acc_next;

    assign w_acc_next = {r_acc, w_rx_byte};

    always_comb begin
        w_get_byte = w_rise_en && (r_state == WAIT);
`ifdef INTERBYTE_GAP_EN
        if (r_gap) begin
            w_get_byte = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_tx_byte  <= '0;
            r_byte_cnt <= '0;
            r_acc      <= '0;
            r_dout     <= '0;
            r_ss       <= 1'b1;
`ifdef INTERBYTE_GAP_EN
            r_gap      <= 1'b0;
`endif
        end else if (w_rise_en) begin
            case (r_state)
                IDLE: begin
                    r_ss <= 1'b1;
                    if (sndRec) begin
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    // DIN is sampled here only; later changes are ignored.
                    r_ss       <= 1'b0;
                    r_tx_byte  <= DIN;
                    r_byte_cnt <= '0;
                    r_acc      <= '0;
`ifdef INTERBYTE_GAP_EN
                    r_gap      <= 1'b0;
`endif
                    r_state    <= WAIT;
                end
                WAIT: begin
`ifdef INTERBYTE_GAP_EN
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else begin
                        r_state <= CHECK;
                    end
`else
                    r_state <= CHECK;
`endif
                end
                CHECK: begin
                    if (w_done) begin
                        r_acc <= w_acc_next[c_ACC_W-1:0];
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_ss    <= 1'b1;
                            r_dout  <= w_acc_next;
                            r_state <= DONE;
                        end else begin
                            r_tx_byte  <= '0;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef INTERBYTE_GAP_EN
                            r_gap      <= 1'b1;
`endif
                            r_state    <= WAIT;
                        end
                    end
                end
                DONE: begin
                    // Held-high sndRec parks here so it cannot retrigger.
                    if (!sndRec) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte shifter
    // ------------------------------------------------------------------
    spi_mode0_shifter u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .i_rise_en (w_rise_en),
        .i_fall_en (w_fall_en),
        .i_start   (w_get_byte),
        .i_tx_byte (r_tx_byte),
        .i_miso    (MISO),
        .o_sclk    (SCLK),
        .o_mosi    (MOSI),
        .o_rx_byte (w_rx_byte),
        .o_done    (w_done)
    );

    assign SS   = r_ss;
    assign DOUT = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_jstk_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jstk_spi_master
//  Description : Self-checking bench for jstk_spi_master. A mode-0 slave
//                model shifts a 40-bit word out on MISO (changing after each
//                falling SCLK) and records MOSI at each rising SCLK. Expected
//                DOUT and MOSI streams come from the transaction rules:
//                DOUT = slave word, MOSI = {command, 32 zero bits}.
//                A second instance at HALF_DIV=750 checks SCLK phase length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jstk_spi_master;

    localparam int H   = 4;
    localparam int PER = 2 * H;     // CLK cycles per serial period
`ifdef INTERBYTE_GAP_EN
    localparam int GAP_PERIODS = 4; // one extra period between each byte pair
`else
    localparam int GAP_PERIODS = 0;
`endif
    // SS low for 50 serial periods: INIT (1), then 10 per byte (WAIT, eight
    // SCLK pulses, completion hand-back) with the last hand-back coinciding
    // with SS rising: 1 + 5*10 - 1.
    localparam int SS_LOW_CYC = (50 + GAP_PERIODS) * PER;
    localparam int SLOW_H     = 750;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, snd_rec, miso;
    logic [7:0]  din;
    logic        ss, sclk, mosi;
    logic [39:0] dout;

    logic        rst_s, snd_s, miso_s;
    logic [7:0]  din_s;
    logic        ss_s, sclk_s, mosi_s;
    logic [39:0] dout_s;

    jstk_spi_master #(.HALF_DIV(H)) u_dut (
        .CLK(clk), .RST(rst), .sndRec(snd_rec), .DIN(din), .MISO(miso),
        .SS(ss), .SCLK(sclk), .MOSI(mosi), .DOUT(dout)
    );

    jstk_spi_master #(.HALF_DIV(SLOW_H)) u_dut_slow (
        .CLK(clk), .RST(rst_s), .sndRec(snd_s), .DIN(din_s), .MISO(miso_s),
        .SS(ss_s), .SCLK(sclk_s), .MOSI(mosi_s), .DOUT(dout_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- slave model and monitors ----------------
    logic [39:0] slave_data = '0;
    logic [39:0] slave_sr   = '0;
    bit          mosi_q[$];
    int          cyc = 0, last_edge = 0;
    int          ss_low_cnt = 0, ss_low_last = 0, ss_fall_cnt = 0;
    int          pulse_cnt = 0, phase_bad = 0, ss_bad = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0;

    int          s_rises = 0, s_rise_t = 0, s_fall_t = 0, s_hi = 0, s_lo = 0;
    logic        s_ss_at_rise = 1'b1, s_mosi_at_rise = 1'b1, p_sclk_s = 1'b0;
    bit          s_done = 1'b0;

    initial miso = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (prev_ss === 1'b1 && ss === 1'b0) begin
            ss_fall_cnt++;
            ss_low_cnt = 0;
            pulse_cnt  = 0;
            mosi_q.delete();
            slave_sr   = slave_data;
            miso       = slave_sr[39];
        end
        if (ss === 1'b0) ss_low_cnt++;
        if (prev_ss === 1'b0 && ss === 1'b1) ss_low_last = ss_low_cnt;

        if (prev_sclk === 1'b0 && sclk === 1'b1) begin
            pulse_cnt++;
            mosi_q.push_back(mosi);
            if (ss !== 1'b0) ss_bad++;
            if (!rst && (pulse_cnt % 8) != 1 && (cyc - last_edge) != H) phase_bad++;
            last_edge = cyc;
        end
        if (prev_sclk === 1'b1 && sclk === 1'b0) begin
            if (!rst && (cyc - last_edge) != H) phase_bad++;
            last_edge = cyc;
            slave_sr  = {slave_sr[38:0], 1'b0};
            miso      = slave_sr[39];
        end
        prev_ss   = ss;
        prev_sclk = sclk;

        // Slow instance: first high phase and following low phase.
        if (p_sclk_s === 1'b0 && sclk_s === 1'b1) begin
            s_rises++;
            if (s_rises == 1) begin
                s_ss_at_rise   = ss_s;
                s_mosi_at_rise = mosi_s;
            end
            if (s_rises == 2) begin
                s_lo   = cyc - s_fall_t;
                s_done = 1'b1;
            end
            s_rise_t = cyc;
        end
        if (p_sclk_s === 1'b1 && sclk_s === 1'b0) begin
            if (s_rises == 1) s_hi = cyc - s_rise_t;
            s_fall_t = cyc;
        end
        p_sclk_s = sclk_s;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ss(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ss === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic [7:0] cmd, input logic [39:0] data,
                          input bit change_din, input int hold, input string tag);
        bit          ok;
        int          falls0;
        logic [39:0] got;
        falls0     = ss_fall_cnt;
        slave_data = data;
        din        = cmd;
        snd_rec    = 1'b1;
        wait_ss(1'b0, 6 * PER, ok);
        check({tag, ".ss_fall"}, 64'(ok), 64'd1);
        if (change_din) begin
            repeat (3 * PER) @(negedge clk);
            din = ~cmd;
        end
        wait_ss(1'b1, SS_LOW_CYC + 10 * PER, ok);
        check({tag, ".ss_rise"}, 64'(ok), 64'd1);
        check({tag, ".dout"}, 64'(dout), 64'(data));
        check({tag, ".pulses"}, 64'(pulse_cnt), 64'd40);
        got = '0;
        foreach (mosi_q[i]) got = {got[38:0], mosi_q[i]};
        check({tag, ".mosi_bits"}, 64'(got), 64'({cmd, 32'h0}));
        check({tag, ".ss_low_cycles"}, 64'(ss_low_last), 64'(SS_LOW_CYC));
        repeat (hold) @(negedge clk);
        snd_rec = 1'b0;
        check({tag, ".ss_windows"}, 64'(ss_fall_cnt - falls0), 64'd1);
        repeat (2 * PER) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        rst = 1'b1; snd_rec = 1'b0; din = 8'h00;
        rst_s = 1'b1; snd_s = 1'b1; din_s = 8'h00; miso_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ss",   64'(ss),   64'd1);
        check("reset.sclk", 64'(sclk), 64'd0);
        check("reset.mosi", 64'(mosi), 64'd0);
        check("reset.dout", 64'(dout), 64'd0);
        rst = 1'b0; rst_s = 1'b0;
        repeat (2 * PER) @(negedge clk);

        do_txn(8'h83, 40'h12_3456_789A, 1'b0, 0, "directed");
        do_txn(8'($urandom), {8'($urandom), 32'($urandom)}, 1'b1, 0, "din_change");
        // Held request for about three transactions' time: one window only.
        do_txn(8'($urandom), {8'($urandom), 32'($urandom)}, 1'b0, 3 * 55 * PER, "hold");
        do_txn(8'($urandom), {8'($urandom), 32'($urandom)}, 1'b0, 0, "reassert");

        // Reset in the middle of a transfer.
        slave_data = {8'($urandom), 32'($urandom)};
        din = 8'($urandom);
        snd_rec = 1'b1;
        wait_ss(1'b0, 6 * PER, ok);
        check("abort.ss_fall", 64'(ok), 64'd1);
        repeat (12 * PER) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort.ss",   64'(ss),   64'd1);
        check("abort.sclk", 64'(sclk), 64'd0);
        check("abort.mosi", 64'(mosi), 64'd0);
        check("abort.dout", 64'(dout), 64'd0);
        rst = 1'b0; snd_rec = 1'b0;
        repeat (2 * PER) @(negedge clk);
        do_txn(8'($urandom), {8'($urandom), 32'($urandom)}, 1'b0, 0, "post_abort");

        for (int k = 0; k < 3; k++) begin
            do_txn(8'($urandom), {8'($urandom), 32'($urandom)}, 1'b0, 0, "random");
        end

        check("sclk_phase_errors", 64'(phase_bad), 64'd0);
        check("ss_high_during_sclk", 64'(ss_bad), 64'd0);

        // Slow instance: each SCLK phase is HALF_DIV CLK cycles.
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (s_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("div750.seen", 64'(ok), 64'd1);
        check("div750.high", 64'(s_hi), 64'(SLOW_H));
        check("div750.low",  64'(s_lo), 64'(SLOW_H));
        check("div750.ss_low", 64'(s_ss_at_rise), 64'd0);
        check("div750.mosi_cmd0", 64'(s_mosi_at_rise), 64'd0);
        check("div750.dout_idle", 64'(dout_s), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jstk_spi_master.md
Name: jstk_spi_master

Overview:
- SPI mode-0 master for the PmodJSTK joystick.
- Divides the 100 MHz system clock into a 66.67 kHz serial clock.
- On request, runs one 5-byte full-duplex transaction: command byte DIN out, then 0x00 ×4. Returns the 40 received bits on DOUT.
- Sits between the board clock domain and the Pmod header. Everything is clocked on CLK; the serial clock acts only as an enable.

Parameters:
- HALF_DIV, 750: CLK cycles per half serial-clock period. 100 MHz / (2×750) = 66.67 kHz, period 15 µs. Must be ≥2.
- NUM_BYTES, 5: bytes per transaction.

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  reset, synchronous, active-high
- sndRec  in  1  transaction request, level-sensitive
- DIN  in  8  command byte, sent first
- MISO  in  1  master-in slave-out
- SS  out  1  slave select, active low
- SCLK  out  1  serial clock, idle low
- MOSI  out  1  master-out slave-in
- DOUT  out  40  received data; first byte in [39:32], last byte in [7:0]

Behaviour:
- Reset values (RST high at a CLK edge): SS=1, SCLK=0, MOSI=0, DOUT=0. Divider counter=0, iSCLK=0, FSM=IDLE.
- A reset mid-transaction aborts it; DOUT is not updated.
- Divider:
  - Counter runs 0..HALF_DIV-1; at terminal count it wraps and toggles internal iSCLK.
  - rise_en / fall_en are single-CLK pulses on the 0→1 / 1→0 toggles.
  - All FSM and shift activity advances only on these pulses.
- Controller FSM, evaluated on rise_en:
  - IDLE: SS=1. If sndRec=1, go to INIT.
  - INIT: SS=0. Load byte 0 = DIN, byte counter = 0. Go to WAIT, which gives one serial period of SS-low setup before the first SCLK.
  - WAIT: start the shifter (getByte pulse) and go to CHECK.
  - CHECK:
    - When the shifter reports done, shift the received byte into a 40-bit accumulator from the LSB end (acc = {acc[31:0], rx}).
    - If 5 bytes are done, go to DONE. Otherwise load 0x00, increment the counter and return to WAIT.
  - DONE: SS=1 and DOUT=acc, both in the same cycle. Stay in DONE while sndRec=1; go to IDLE when sndRec=0.
  - One transaction per sndRec assertion. A held-high sndRec does not retrigger.
- Shifter (SPI mode 0, MSB first, 8 bits):
  - On start, MOSI=bit7 before the first SCLK rise.
  - SCLK = iSCLK while the byte is active, else 0.
  - MISO is sampled on each rising SCLK edge (rise_en).
  - MOSI shifts to the next bit on each falling edge (fall_en).
  - After the 8th rising edge, SCLK returns low at the following fall_en and done is asserted. Exactly 8 SCLK pulses per byte.
- MOSI is 0 whenever no byte is active.
- DIN is captured only in INIT; later changes to DIN are ignored until the next transaction.
- sndRec dropping during a transaction does not abort it.

Optional Feature:
- Macro: INTERBYTE_GAP_EN.
- Defined: WAIT holds for one extra full serial period between consecutive bytes with SS still low (≥10 µs slave processing gap). First-byte setup is unchanged.
- Undefined: bytes go back-to-back, with one WAIT pass only.
- DOUT contents are identical either way; only timing differs.

Decomposition:
- Package jstk_pkg: FSM state enum (IDLE, INIT, WAIT, CHECK, DONE), NUM_BYTES=5, BYTE_W=8, DOUT_W=40.
- Sub-module spi_mode0_shifter holds the 8-bit shift register, bit counter, SCLK gating and done flag. Divider and FSM live in the top.

Test Plan (HALF_DIV=4 unless stated):
- Reset: hold RST high for 3 cycles mid-transfer → SS=1, SCLK=0, MOSI=0, DOUT=0 on the next edge. A later sndRec runs a clean transaction.
- Divider: HALF_DIV=750, monitor SCLK during a byte → high and low phases each exactly 750 CLK cycles (15 µs period).
- Receive: slave model drives 0x12,0x34,0x56,0x78,0x9A on MISO (changing after falling SCLK) → DOUT=0x123456789A after SS rises.
- Transmit: DIN=0x83 → MOSI sampled at SCLK rises reads 1000_0011, then 32 zero bits. 40 SCLK pulses total with SS low throughout.
- Handshake: hold sndRec high for 3 transactions' worth of time → exactly one SS-low window. Drop and reassert sndRec → second transaction. Change DIN mid-transfer → no effect on bits sent.
- Gap: build with and without INTERBYTE_GAP_EN → SS-low duration differs by 4 serial periods (8×HALF_DIV CLK cycles); DOUT is identical.
